// File: rtl/hex_pkg.sv
// rtl/hex_pkg.sv - shared constants for the multiplexed hex display driver
// Contents: digit count, index width, active-low segment codes for 0..F,
// blank code, and a helper that finds the most significant nonzero nibble.
package hex_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = 3;

    // Active-low segment codes, bit0=a .. bit6=g, indexed by nibble value.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index of the highest nonzero nibble; 0 when the word is all zeros so
    // that digit 0 is never treated as a leading zero.
    function automatic logic [IDX_W-1:0] msd_index(input logic [4*NUM_DIGITS-1:0] word);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (word[4*k +: 4] != 4'h0) begin
                r = k[IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational nibble to active-low 7-segment decoder
// Ports: nibble (4-bit value 0..F) -> seg_n (7-bit active-low, bit0=a .. bit6=g)
module hex_to_seg7
    import hex_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_scan_driver.sv
// rtl/hex_scan_driver.sv - 8-digit multiplexed hex display scanner with tear-free updates
// Ports: clock, reset_n (async active-low); data_in/load_valid/load_ready word
// handshake into a one-entry pending register; blank_lz leading-zero suppression;
// seg_n (active-low segments), dig_sel_n (active-low one-hot digit enable),
// frame_done (one-cycle pulse after each full 8-digit scan).
module hex_scan_driver
    import hex_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic                    blank_lz,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   dig_sel_n,
    output logic                    frame_done
);

    localparam int              PW         = $clog2(CLK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc, presc_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [4*NUM_DIGITS-1:0] shown, shown_nxt;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pend_full, pend_full_nxt;
    logic                    tick, boundary, load_fire;
    logic [3:0]              nibble;
    logic [6:0]              seg_code;
    logic                    lz_blank;
    logic [6:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   dig_nxt;

    assign load_ready = ~pend_full;

    // Outputs are computed from next-state values and registered, so the
    // registered seg_n/dig_sel_n always agree with the registered prescaler
    // and index while having no combinational path from any input.
    always_comb begin
        tick          = (presc == PRESC_LAST);
        boundary      = tick && (idx == IDX_LAST);
        presc_nxt     = tick ? '0 : presc + 1'b1;
        idx_nxt       = tick ? idx + 1'b1 : idx;
        load_fire     = load_valid && !pend_full;
        // The shown word only changes on the frame boundary, so no digit tears.
        shown_nxt     = (boundary && pend_full) ? pending : shown;
        pend_full_nxt = load_fire || (pend_full && !boundary);
        nibble        = shown_nxt[4*idx_nxt +: 4];
        lz_blank      = blank_lz && (idx_nxt > msd_index(shown_nxt));
        seg_nxt       = lz_blank ? SEG_BLANK : seg_code;
        // Blank cycle at prescaler 0 stops ghosting while the digit switches.
        dig_nxt       = (presc_nxt == '0) ? '1 : ~(NUM_DIGITS'(1) << idx_nxt);
    end

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .seg_n  (seg_code)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc      <= '0;
            idx        <= '0;
            shown      <= '0;
            pending    <= '0;
            pend_full  <= 1'b0;
            seg_n      <= SEG_BLANK;
            dig_sel_n  <= '1;
            frame_done <= 1'b0;
        end else begin
            presc      <= presc_nxt;
            idx        <= idx_nxt;
            shown      <= shown_nxt;
            pend_full  <= pend_full_nxt;
            if (load_fire) begin
                pending <= data_in;
            end
            seg_n      <= seg_nxt;
            dig_sel_n  <= dig_nxt;
            frame_done <= boundary;
        end
    end

endmodule
